fir_decim_avg: RTL and testbench
================================

Name: fir_decim_avg

Overview:
- Downstream stage of the 4-tap FIR (4-bit x in, 8-bit y out).
- Consumes the FIR's 8-bit unsigned output on a sample strobe. The strobe is the FIR's divided-clock update tick, supplied as a one-cycle pulse in the clk domain.
- Averages each non-overlapping window of DECIM samples and presents one 8-bit result per window on a valid/ready output port.
- Reduces the output data rate for display or serial readout stages.

Parameters:
- DECIM, 4: window length. Must be a power of 2 in the range 2..16.
- IN_W, 8: input sample width. Matches the FIR y width.
- LOG_D, $clog2(DECIM): shift amount. Derived; do not override.
- ACC_W, IN_W+LOG_D: accumulator width. Derived; do not override.

Ports:
- clk  in  1  Single system clock. All logic is rising-edge.
- rst  in  1  Asynchronous, active-low reset (0 = reset).
- clr  in  1  Synchronous window restart, active-high.
- in_valid  in  1  One-cycle strobe: in_data holds a new FIR output sample.
- in_data  in  IN_W  Unsigned FIR output sample.
- out_valid  out  1  Result held and pending transfer.
- out_ready  in  1  Consumer accepts the result.
- out_data  out  IN_W  Window average.
- overrun  out  1  Sticky flag: at least one completed result was dropped.
- phase  out  LOG_D  Number of samples accumulated in the current window.

Behaviour:
- Reset (rst=0, asynchronous):
  - acc=0, phase=0, out_valid=0, out_data=0, overrun=0.
  - Reset mid-window discards the partial sum. No output is produced for that window.
- Two states:
  - COLLECT: out_valid=0.
  - HOLD: out_valid=1.
  - Accumulation continues in both states. State only tracks whether the output register is occupied.
- Sample accept, every cycle with in_valid=1:
  - If phase < DECIM-1: acc <= acc + in_data, phase <= phase+1.
  - If phase == DECIM-1 (last sample): sum = acc + in_data (ACC_W bits, cannot overflow). acc <= 0, phase <= 0 (wrap).
- Result computation: result = sum >> LOG_D, truncating. The result always fits in IN_W bits.
- Latency: out_valid rises on the clock edge that accepts the last sample of the window. It is visible the cycle after in_valid.
- Output handshake:
  - A transfer occurs on any cycle with out_valid=1 and out_ready=1.
  - A transfer in HOLD with no new result returns the block to COLLECT.
  - out_data is stable while out_valid=1 and no transfer occurs.
  - out_ready is ignored while out_valid=0.
- New result with the output register free or freeing: if out_valid=0, or out_valid=1 and out_ready=1 in the same cycle, the new result loads. out_valid stays/becomes 1 with no overrun.
- New result with the output register blocked: if out_valid=1 and out_ready=0, the new result is discarded and overrun <= 1. out_data keeps the older result (oldest-wins).
- overrun clears only on rst=0 or clr=1.
- clr=1:
  - acc <= 0, phase <= 0, overrun <= 0.
  - A held output is not cleared and stays pending.
  - If in_valid=1 in the same cycle, that sample is discarded (clr has priority).
- in_valid on consecutive cycles is legal. One sample is accepted per cycle.

Optional Feature:
- Macro: FIR_DECIM_ROUND_EN.
- Defined: result = (sum + DECIM/2) >> LOG_D (round half up). No saturation logic is needed: the maximum is (255*DECIM + DECIM/2) >> LOG_D = 255.
- Undefined: the result truncates, as described above.

Decomposition:
- Shared package fir_pkg holds:
  - FIR_SAMPLE_W = 8.
  - A typedef fir_sample_t for the IN_W-bit sample.
  - The state enum {COLLECT, HOLD}.
- One sub-module is natural: fir_win_acc, containing the accumulator, the phase counter, wrap detection and the rounding/shift.
- The top level holds the output register, the handshake FSM and overrun.

Test Plan:
- DECIM=4, out_ready=1, samples 10,20,30,40 -> out_valid for 1 cycle after the 4th strobe, out_data=25, overrun=0.
- Samples 1,2,2,2 -> out_data=1 without FIR_DECIM_ROUND_EN, 2 with it. Four samples of 255 -> out_data=255 in both builds.
- out_ready=0, 8 strobes (windows of 4x10 then 4x50) -> out_data holds 10, overrun=1 after the 8th strobe. Then out_ready=1 -> a single transfer of 10, out_valid=0.
- out_valid=1 with out_ready=1 on the same cycle as a window's last strobe -> old result transferred, new result loaded, out_valid stays 1, overrun=0.
- 2 strobes, then clr=1 together with a strobe, then 4 strobes of 8 -> phase=0 after clr, out_data=8, overrun=0.
- 3 strobes, then rst=0 pulse between clock edges -> all outputs 0 immediately. The next 4 strobes of 4 -> out_data=4.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output chain: sample width, sample type and
// the output-register FSM states of the decimating averager.
package fir_pkg;

  localparam int FIR_SAMPLE_W = 8;

  typedef logic [FIR_SAMPLE_W-1:0] fir_sample_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } fir_state_t;

endpackage

// File: rtl/fir_decim_avg_if.sv
// Sample-in / result-out port bundle of the decimating averager.
// Handshake: a result transfers on any cycle where out_valid=1 and out_ready=1;
// in_valid is a one-cycle strobe with no back-pressure.
interface fir_decim_avg_if #(
  parameter int IN_W = 8
);
  logic            in_valid;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [IN_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/fir_win_acc.sv
// Window accumulator: sums DECIM samples, flags the last one and produces the
// average. Define FIR_DECIM_ROUND_EN for round-half-up instead of truncation.
module fir_win_acc
  import fir_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int IN_W  = FIR_SAMPLE_W,
  parameter int LOG_D = $clog2(DECIM),
  parameter int ACC_W = IN_W + LOG_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_data,
  output logic [LOG_D-1:0] o_phase,
  output logic             o_done,
  output logic [IN_W-1:0]  o_result
);

  logic [ACC_W-1:0] r_acc;
  logic [LOG_D-1:0] r_phase;
  logic             w_accept;
  logic             w_last;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_adj;

  // clr wins over a coincident strobe, so that sample never enters the sum
  assign w_accept = i_valid & ~i_clr;
  assign w_last   = w_accept & (r_phase == LOG_D'(DECIM - 1));
  assign w_sum    = r_acc + ACC_W'(i_data);

`ifdef FIR_DECIM_ROUND_EN
  assign w_adj = w_sum + ACC_W'(DECIM / 2);
`else
  assign w_adj = w_sum;
`endif

  assign o_result = IN_W'(w_adj >> LOG_D);
  assign o_done   = w_last;
  assign o_phase  = r_phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      r_phase <= '0;
    end else if (i_clr) begin
      r_acc   <= '0;
      r_phase <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc   <= '0;
        r_phase <= '0;
      end else begin
        r_acc   <= w_sum;
        r_phase <= r_phase + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_decim_avg.sv
// Decimating averager behind the 4-tap FIR: one averaged result per DECIM
// samples, held in an oldest-wins output register with a sticky overrun flag.
// Optional macro FIR_DECIM_ROUND_EN selects round-half-up averaging.
module fir_decim_avg
  import fir_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int IN_W  = FIR_SAMPLE_W,
  parameter int LOG_D = $clog2(DECIM),
  parameter int ACC_W = IN_W + LOG_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  fir_decim_avg_if.slave         bus,
  output logic                   overrun,
  output logic [LOG_D-1:0]       phase,
  output fir_state_t             dbg_state
);

  fir_state_t      r_state;
  fir_state_t      w_state_nxt;
  logic [IN_W-1:0] r_out_data;
  logic            r_overrun;
  logic            w_done;
  logic [IN_W-1:0] w_result;
  logic            w_load;
  logic            w_drop;

  fir_win_acc #(
    .DECIM (DECIM),
    .IN_W  (IN_W),
    .LOG_D (LOG_D),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (clr),
    .i_valid  (bus.in_valid),
    .i_data   (bus.in_data),
    .o_phase  (phase),
    .o_done   (w_done),
    .o_result (w_result)
  );

  // A result arriving while HOLD is being drained still loads (register frees)
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_done) begin
          w_load      = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (w_done) begin
          if (bus.out_ready) w_load = 1'b1;
          else               w_drop = 1'b1;
        end else if (bus.out_ready) begin
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= COLLECT;
      r_out_data <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_out_data <= w_result;
      if (clr)         r_overrun <= 1'b0;
      else if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_data  = r_out_data;
  assign overrun       = r_overrun;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_fir_decim_avg.sv
// Directed bench for fir_decim_avg (DECIM=4): window averaging, rounding,
// oldest-wins overrun, same-cycle reload, clr and mid-window async reset.
module tb_fir_decim_avg;
  import fir_pkg::*;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       overrun;
  logic [1:0] phase;
  fir_state_t dbg_state;
  int         n_vec;
  int         n_err;
  logic [7:0] exp_rnd;

  fir_decim_avg_if #(.IN_W(8)) bus ();

  fir_decim_avg #(.DECIM(4), .IN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .bus       (bus.slave),
    .overrun   (overrun),
    .phase     (phase),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one strobe at a negedge; returns at the next negedge, after the accept edge
  task automatic strobe(input logic [7:0] d);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    idle(2);
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || overrun !== 1'b0 || phase !== 2'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%0d ov=%b ph=%0d want 0 0 0 0",
               bus.out_valid, bus.out_data, overrun, phase);
    end
    n_vec++;
    if (dbg_state !== COLLECT) begin
      n_err++; $display("FAIL reset_state: got %0d want %0d", int'(dbg_state), int'(COLLECT));
    end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_basic;
    bus.out_ready = 1'b1;
    strobe(8'd10); strobe(8'd20);
    n_vec++;
    if (phase !== 2'd2) begin n_err++; $display("FAIL basic_phase: got %0d want 2", phase); end
    strobe(8'd30); strobe(8'd40);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd25 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result: got v=%b d=%0d ov=%b want 1 25 0", bus.out_valid, bus.out_data, overrun);
    end
    idle(1);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_one_cycle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_rounding;
`ifdef FIR_DECIM_ROUND_EN
    exp_rnd = 8'd2;
`else
    exp_rnd = 8'd1;
`endif
    strobe(8'd1); strobe(8'd2); strobe(8'd2); strobe(8'd2);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_rnd) begin
      n_err++; $display("FAIL round_7_4: got v=%b d=%0d want 1 %0d", bus.out_valid, bus.out_data, exp_rnd);
    end
    idle(1);
    for (int i = 0; i < 4; i++) strobe(8'd255);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd255) begin
      n_err++; $display("FAIL round_max: got v=%b d=%0d want 1 255", bus.out_valid, bus.out_data);
    end
    idle(1);
  endtask

  task automatic test_overrun;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(8'd10);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd10 || overrun !== 1'b0) begin
      n_err++; $display("FAIL ovr_first: got v=%b d=%0d ov=%b want 1 10 0", bus.out_valid, bus.out_data, overrun);
    end
    for (int i = 0; i < 4; i++) strobe(8'd50);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd10 || overrun !== 1'b1) begin
      n_err++; $display("FAIL ovr_drop: got v=%b d=%0d ov=%b want 1 10 1", bus.out_valid, bus.out_data, overrun);
    end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd10 || overrun !== 1'b0) begin
      n_err++; $display("FAIL clr_keeps_held: got v=%b d=%0d ov=%b want 1 10 0", bus.out_valid, bus.out_data, overrun);
    end
    bus.out_ready = 1'b1;
    idle(1);
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd10) begin
      n_err++; $display("FAIL ovr_drain: got v=%b d=%0d want 0 10", bus.out_valid, bus.out_data);
    end
    idle(1);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ovr_single_xfer: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_clr;
    bus.out_ready = 1'b1;
    strobe(8'd99); strobe(8'd99);
    @(negedge clk);
    clr = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'd200;
    @(negedge clk);
    clr = 1'b0; bus.in_valid = 1'b0;
    n_vec++;
    if (phase !== 2'd0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL clr_phase: got ph=%0d ov=%b want 0 0", phase, overrun);
    end
    for (int i = 0; i < 4; i++) strobe(8'd8);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd8 || overrun !== 1'b0) begin
      n_err++; $display("FAIL clr_window: got v=%b d=%0d ov=%b want 1 8 0", bus.out_valid, bus.out_data, overrun);
    end
    idle(1);
  endtask

  task automatic test_back_to_back;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(8'd12);
    for (int i = 0; i < 3; i++) strobe(8'd20);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 8'd20; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd20 || overrun !== 1'b0) begin
      n_err++; $display("FAIL reload_same_cycle: got v=%b d=%0d ov=%b want 1 20 0", bus.out_valid, bus.out_data, overrun);
    end
    n_vec++;
    if (dbg_state !== HOLD) begin
      n_err++; $display("FAIL reload_state: got %0d want %0d", int'(dbg_state), int'(HOLD));
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) strobe(8'd100);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || overrun !== 1'b0 || phase !== 2'd0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b d=%0d ov=%b ph=%0d want 0 0 0 0",
               bus.out_valid, bus.out_data, overrun, phase);
    end
    #1 rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) strobe(8'd4);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd4) begin
      n_err++; $display("FAIL reset_fresh_window: got v=%b d=%0d want 1 4", bus.out_valid, bus.out_data);
    end
    idle(1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset;
    test_basic;
    test_rounding;
    test_overrun;
    test_clr;
    test_back_to_back;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
